// File: rtl/note_key_encoder_pkg.sv
// Shared constants and types for the note key encoder.
// Note codes, key bit positions and the player FSM states.
package note_key_encoder_pkg;

  localparam int NUM_KEYS = 7;

  localparam logic [2:0] NOTA_DO  = 3'd0;
  localparam logic [2:0] NOTA_RE  = 3'd1;
  localparam logic [2:0] NOTA_MI  = 3'd2;
  localparam logic [2:0] NOTA_FA  = 3'd3;
  localparam logic [2:0] NOTA_SOL = 3'd4;
  localparam logic [2:0] NOTA_LA  = 3'd5;
  localparam logic [2:0] NOTA_SI  = 3'd6;

  localparam int KEY_DO   = 0;
  localparam int KEY_RE   = 1;
  localparam int KEY_MI   = 2;
  localparam int KEY_FA   = 3;
  localparam int KEY_SOL  = 4;
  localparam int KEY_LA   = 5;
  localparam int KEY_SI   = 6;
  localparam int KEY_SUST = 7;

  typedef enum logic {
    OCIOSO  = 1'b0,
    TOCANDO = 1'b1
  } estado_t;

  // Lowest set key wins; scanning downward lets the lowest overwrite.
  function automatic logic [2:0] encode_nota(
    input logic [NUM_KEYS-1:0] keys
  );
    logic [2:0] n;
    n = NOTA_DO;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) n = 3'(i);
    end
    return n;
  endfunction

endpackage

// File: rtl/debounce_teclas.sv
// Two-flop synchronizer followed by a whole-vector debouncer.
// The stable vector only moves after DEBOUNCE_CYCLES equal samples.
module debounce_teclas #(
  parameter int W               = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] PRE  = CW'(DEBOUNCE_CYCLES - 2);

  logic [W-1:0]  sync1_q;
  logic [W-1:0]  sync2_q;
  logic [W-1:0]  cand_q;
  logic [W-1:0]  cand_d;
  logic [W-1:0]  stable_q;
  logic [W-1:0]  stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Synchronizer chain for the asynchronous key inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Candidate tracking, saturating run counter and stable update.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != LAST) cnt_d = cnt_q + CW'(1);
      if (cnt_q == PRE || cnt_q == LAST) stable_d = cand_q;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/note_key_encoder.sv
// Debounced note keyboard to note code plus sharp flag.
// Emits a one-cycle pulse whenever the played note changes.
module note_key_encoder
  import note_key_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] TECLAS,
  input  logic       SUSTENIDO,
  output logic [2:0] NOTAS,
  output logic       TOM,
  output logic       NOTA_VALIDA,
  output logic       NOVA_NOTA
);

  logic [7:0]          stable_w;
  logic [NUM_KEYS-1:0] keys_w;
  logic                sust_w;
  logic [2:0]          nota_w;
  logic                tom_w;

  estado_t    state_q;
  estado_t    state_d;
  logic [2:0] notas_q;
  logic [2:0] notas_d;
  logic       tom_q;
  logic       tom_d;
  logic       nova_q;
  logic       nova_d;

  debounce_teclas #(
    .W              (8),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .raw_i   ({SUSTENIDO, TECLAS}),
    .stable_o(stable_w)
  );

  assign keys_w = stable_w[KEY_SI:KEY_DO];
  assign sust_w = stable_w[KEY_SUST];
  assign nota_w = encode_nota(keys_w);
  assign tom_w  = sust_w &&
                  (nota_w != NOTA_MI) &&
                  (nota_w != NOTA_SI);

  // Player FSM: next state, output loads and change pulse.
  always_comb begin
    state_d = state_q;
    notas_d = notas_q;
    tom_d   = tom_q;
    nova_d  = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        if (|keys_w) begin
          state_d = TOCANDO;
          notas_d = nota_w;
          tom_d   = tom_w;
          nova_d  = 1'b1;
        end
      end
      TOCANDO: begin
        if (!(|keys_w)) begin
          state_d = OCIOSO;
        end else if (nota_w != notas_q ||
                     tom_w != tom_q) begin
          notas_d = nota_w;
          tom_d   = tom_w;
          nova_d  = 1'b1;
        end
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= OCIOSO;
      notas_q <= NOTA_DO;
      tom_q   <= 1'b0;
      nova_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      notas_q <= notas_d;
      tom_q   <= tom_d;
      nova_q  <= nova_d;
    end
  end

  assign NOTAS       = notas_q;
  assign TOM         = tom_q;
  assign NOVA_NOTA   = nova_q;
  assign NOTA_VALIDA = (state_q == TOCANDO);

endmodule

// File: tb/tb_note_key_encoder.sv
// Bench for note_key_encoder: directed vectors, corner sequences,
// and random stimulus against a queue-based reference model.
module tb_note_key_encoder;

  localparam int D = 4;

  logic       CLK;
  logic       RST;
  logic [6:0] TECLAS;
  logic       SUSTENIDO;
  logic [2:0] NOTAS;
  logic       TOM;
  logic       NOTA_VALIDA;
  logic       NOVA_NOTA;

  int errors = 0;
  int checks = 0;

  note_key_encoder #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .TECLAS     (TECLAS),
    .SUSTENIDO  (SUSTENIDO),
    .NOTAS      (NOTAS),
    .TOM        (TOM),
    .NOTA_VALIDA(NOTA_VALIDA),
    .NOVA_NOTA  (NOVA_NOTA)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [6:0] teclas;
    logic       sust;
    logic [2:0] notas;
    logic       tom;
    logic       valida;
    logic       pulse;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge right after new inputs were driven.
  task automatic settle(input string name,
                        input logic [2:0] en,
                        input logic et,
                        input logic ev,
                        input logic ep);
    int early;
    early = 0;
    repeat (D + 2) begin
      @(negedge CLK);
      if (NOVA_NOTA) early++;
    end
    chk({name, "_early"}, early, 0);
    @(negedge CLK);
    chk({name, "_pulse"}, 32'(NOVA_NOTA), 32'(ep));
    chk({name, "_out"}, {NOTA_VALIDA, TOM, NOTAS},
        {ev, et, en});
    @(negedge CLK);
    chk({name, "_drop"}, 32'(NOVA_NOTA), 0);
  endtask

  // Reference model: raw delay line, last-D sample window, note rules.
  logic [7:0] m_pipe[$];
  logic [7:0] m_hist[$];
  logic [7:0] m_stable;
  logic [2:0] m_notas;
  logic       m_tom;
  logic       m_val;
  logic       m_pulse;

  task automatic model_step(input logic [7:0] raw, input logic rst);
    logic [6:0] k;
    logic [2:0] n;
    logic       t;
    logic [7:0] s;
    bit         same;
    if (rst) begin
      m_pipe   = '{8'h00, 8'h00};
      m_hist   = '{8'h00};
      m_stable = 8'h00;
      m_notas  = 3'd0;
      m_tom    = 1'b0;
      m_val    = 1'b0;
      m_pulse  = 1'b0;
    end else begin
      k = m_stable[6:0];
      m_pulse = 1'b0;
      if (k != 0) begin
        n = 3'd0;
        for (int i = 0; i < 7; i++) begin
          if (k[i]) begin
            n = 3'(i);
            break;
          end
        end
        t = m_stable[7] && n != 3'd2 && n != 3'd6;
        m_pulse = !m_val || n != m_notas || t != m_tom;
        m_notas = n;
        m_tom   = t;
        m_val   = 1'b1;
      end else begin
        m_val = 1'b0;
      end
      s = m_pipe.pop_front();
      m_pipe.push_back(raw);
      m_hist.push_back(s);
      if (m_hist.size() > D) void'(m_hist.pop_front());
      if (m_hist.size() == D) begin
        same = 1'b1;
        foreach (m_hist[j]) if (m_hist[j] != s) same = 1'b0;
        if (same) m_stable = s;
      end
    end
  endtask

  initial begin
    int hold;
    int pulses;
    logic [6:0] rt;
    logic       rs;
    logic       rr;

    vecs[0]  = '{7'b0000100, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{7'b0000000, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{7'b0000000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{7'b0010000, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{7'b0000100, 1'b1, 3'd2, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{7'b0100010, 1'b0, 3'd1, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{7'b0100000, 1'b0, 3'd5, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{7'b0100000, 1'b1, 3'd5, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{7'b1000000, 1'b1, 3'd6, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{7'b1000001, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{7'b1000001, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{7'b1000000, 1'b0, 3'd6, 1'b0, 1'b1, 1'b1};

    RST = 1'b1;
    TECLAS = '0;
    SUSTENIDO = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_state", {NOVA_NOTA, NOTA_VALIDA, TOM, NOTAS}, 0);
    RST = 1'b0;

    for (int i = 0; i < 12; i++) begin
      TECLAS = vecs[i].teclas;
      SUSTENIDO = vecs[i].sust;
      settle($sformatf("vec%0d", i), vecs[i].notas,
             vecs[i].tom, vecs[i].valida, vecs[i].pulse);
    end

    // Short DO glitch on top of held SI must be ignored.
    TECLAS = 7'b1000001;
    repeat (3) @(negedge CLK);
    TECLAS = 7'b1000000;
    pulses = 0;
    repeat (2 * D + 6) begin
      @(negedge CLK);
      if (NOVA_NOTA) pulses++;
    end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_out", {NOTA_VALIDA, TOM, NOTAS}, {1'b1, 1'b0, 3'd6});

    TECLAS = 7'b0000000;
    settle("release", 3'd6, 1'b0, 1'b0, 1'b0);

    TECLAS = 7'b1000000;
    settle("si_press", 3'd6, 1'b0, 1'b1, 1'b1);

    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_in_tocando", {NOVA_NOTA, NOTA_VALIDA, TOM, NOTAS}, 0);
    RST = 1'b0;
    settle("si_after_rst", 3'd6, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of debouncing a new key.
    TECLAS = 7'b0000001;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_deb", {NOVA_NOTA, NOTA_VALIDA, TOM, NOTAS}, 0);
    RST = 1'b0;
    settle("do_after_rst", 3'd0, 1'b0, 1'b1, 1'b1);

    // Random phase against the reference model.
    RST = 1'b1;
    model_step(8'h00, 1'b1);
    hold = 0;
    rt = '0;
    rs = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      chk($sformatf("rand_c%0d", c),
          {NOVA_NOTA, NOTA_VALIDA, TOM, NOTAS},
          {m_pulse, m_val, m_tom, m_notas});
      if (hold == 0) begin
        rt = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 3) == 0) rt = '0;
        rs = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      rr = ($urandom_range(0, 199) == 0);
      TECLAS = rt;
      SUSTENIDO = rs;
      RST = rr;
      model_step({rs, rt}, rr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_key_encoder.md
NOTE_KEY_ENCODER -- requirements
Module: note_key_encoder

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive identical synchronized samples needed to accept a key change (range 2..65535).
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port TECLAS, input, 7 bits: raw asynchronous note keys, active-high; bit0=DO, 1=RE, 2=MI, 3=FA, 4=SOL, 5=LA, 6=SI.
REQ-005 SHALL have port SUSTENIDO, input, 1 bit: raw asynchronous sharp-modifier key, active-high.
REQ-006 SHALL have port NOTAS, output, 3 bits: registered note code, 000=DO through 110=SI; 111 is never driven.
REQ-007 SHALL have port TOM, output, 1 bit: registered sharp flag paired with NOTAS.
REQ-008 SHALL have port NOTA_VALIDA, output, 1 bit: high while a debounced note key is held.
REQ-009 SHALL have port NOVA_NOTA, output, 1 bit: one-cycle pulse whenever NOTAS/TOM take a new accepted value.

Function
REQ-010 SHALL pass all 8 raw inputs through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce the 8-bit synchronized vector as a whole: any sample differing from the candidate reloads the stability counter to 0 and replaces the candidate.
REQ-012 SHALL copy the candidate into the stable vector when it has matched on DEBOUNCE_CYCLES consecutive cycles.
REQ-013 SHALL use a counter just wide enough for DEBOUNCE_CYCLES-1 that saturates and never wraps.
REQ-014 SHALL priority-encode the stable keys with the lowest set index winning (DO over RE ... over SI).
REQ-015 SHALL force TOM=0 when the encoded note is MI (010) or SI (110), regardless of SUSTENIDO.
REQ-016 SHALL implement FSM states OCIOSO (no key) and TOCANDO (key held).
REQ-017 OCIOSO -> TOCANDO when stable keys become nonzero: load NOTAS/TOM and pulse NOVA_NOTA in the same cycle.
REQ-018 In TOCANDO, a change in encoded note or effective sharp flag while keys remain nonzero SHALL update NOTAS/TOM and pulse NOVA_NOTA, with no state change.
REQ-019 TOCANDO -> OCIOSO when stable keys become zero: NOTAS/TOM hold last value and NOVA_NOTA stays low.
REQ-020 NOTA_VALIDA SHALL be 1 exactly in state TOCANDO.
REQ-021 Latency from a raw input step (held steady) to NOVA_NOTA SHALL be exactly DEBOUNCE_CYCLES+3 cycles: 2 synchronizer, DEBOUNCE_CYCLES debounce, 1 output register.
REQ-022 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no output change.
REQ-023 A SUSTENIDO change with no note key held SHALL change no output.
REQ-024 Simultaneous key-set and sharp changes settling together SHALL produce a single NOVA_NOTA pulse.

Reset
REQ-025 While RST=1 at a clock edge: synchronizer, candidate and stable vectors = 0, counter = 0, state = OCIOSO, NOTAS=000, TOM=0, NOTA_VALIDA=0, NOVA_NOTA=0.
REQ-026 Reset mid-debounce or in TOCANDO SHALL discard all progress; keys still held after reset release SHALL be re-debounced in full and then produce a fresh NOVA_NOTA.

Structure
REQ-027 Shared package SHALL hold the note code constants (DO..SI), the FSM state enum (OCIOSO, TOCANDO) and the key-index constants.
REQ-028 Synchronizer plus debounce SHALL be one sub-module, debounce_teclas, parameterized by width and DEBOUNCE_CYCLES; encoding, FSM and output registers stay in the top level.

Verification
REQ-029 DEBOUNCE_CYCLES=4, press TECLAS=0000100 steady -> NOVA_NOTA pulse 7 cycles later, NOTAS=010, TOM=0, NOTA_VALIDA=1.
REQ-030 Hold SUSTENIDO=1, press TECLAS=0010000 -> NOTAS=100, TOM=1; then press MI alone with sharp still held -> NOTAS=010, TOM=0.
REQ-031 TECLAS=0100010 (RE+LA) -> NOTAS=001; release RE, keep LA -> second pulse, NOTAS=101.
REQ-032 3-cycle pulse on TECLAS[0] with DEBOUNCE_CYCLES=4 -> outputs unchanged, no NOVA_NOTA.
REQ-033 Release all keys -> NOTA_VALIDA=0 after DEBOUNCE_CYCLES+3 cycles with NOTAS held; assert RST while SI is held -> all outputs 0, and after release SI is re-accepted with a pulse at DEBOUNCE_CYCLES+3 cycles.
